hpm_counter_bank: RTL

- Parametrised bank of hardware performance-monitor counters, mhpmcounter3..(3+NUM_COUNTERS-1), each with its own event selector.
- Generalises the fixed MHPMCOUNTER3..31 CSR map to a configurable counter count and width.
- Adds per-counter inhibit, sticky overflow flags and an overflow interrupt.
- Sits beside the CSR bank; the CSR bank forwards HPM-range accesses to it and merges its read data.

---
 rtl/hpm_counter_bank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hpm_counter_bank.sv
// ============================================================================
// hpm_counter_bank : bank of HPM counters with event selectors, inhibit, ovf/irq
// Revision: 1.0
// ============================================================================
`default_nettype none

module hpm_counter_bank #(
  parameter int NUM_COUNTERS  = 8,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic                  csr_we_i,
  input  logic                  csr_re_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_rvalid_o,
  output logic                  csr_err_o,
  output logic                  irq_o
);

  localparam int          HI_W         = COUNTER_WIDTH - 32;
  localparam logic [11:0] ADDR_LO_BASE = 12'hB03;
  localparam logic [11:0] ADDR_HI_BASE = 12'hB83;
  localparam logic [11:0] ADDR_EV_BASE = 12'h323;
  localparam logic [11:0] ADDR_INH     = 12'h320;
  localparam logic [11:0] ADDR_OVF     = 12'h7D0;
  localparam logic [11:0] ADDR_OVFEN   = 12'h7D1;

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
  logic [7:0]               sel_q [NUM_COUNTERS];
  logic [7:0]               sel_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  inh_q, inh_d, ovf_q, ovf_d, ovfen_q, ovfen_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;

  logic [NUM_COUNTERS-1:0]  inc;
  logic [NUM_COUNTERS-1:0]  wbits;
  logic [31:0]              inh_vec, ovf_vec, ovfen_vec;
  logic [31:0]              rd_val;
  logic                     rd_hit, wr_hit;

  // Register bit idx belongs to counter n = idx-3.
  assign wbits     = csr_wdata_i[NUM_COUNTERS+2:3];
  assign inh_vec   = 32'({inh_q, 3'b000});
  assign ovf_vec   = 32'({ovf_q, 3'b000});
  assign ovfen_vec = 32'({ovfen_q, 3'b000});

  // Out-of-range selector values simply never match an event.
  always_comb begin
    inc = '0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (sel_q[n] == 8'(e + 1) && events_i[e]) inc[n] = 1'b1;
      end
      if (inh_q[n]) inc[n] = 1'b0;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    inh_d   = inh_q;
    ovf_d   = ovf_q;
    ovfen_d = ovfen_q;
    wr_hit  = 1'b0;
    if (csr_we_i) begin
      if (csr_addr_i == ADDR_INH)   begin inh_d   = wbits;          wr_hit = 1'b1; end
      if (csr_addr_i == ADDR_OVF)   begin ovf_d   = ovf_q & ~wbits; wr_hit = 1'b1; end
      if (csr_addr_i == ADDR_OVFEN) begin ovfen_d = wbits;          wr_hit = 1'b1; end
    end
    // Overflow set is applied after the W1C so a coincident clear loses.
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      if (csr_we_i && csr_addr_i == ADDR_LO_BASE + 12'(n)) begin
        cnt_d[n][31:0] = csr_wdata_i;
        wr_hit = 1'b1;
      end else if (csr_we_i && csr_addr_i == ADDR_HI_BASE + 12'(n)) begin
        cnt_d[n][COUNTER_WIDTH-1:32] = csr_wdata_i[HI_W-1:0];
        wr_hit = 1'b1;
      end else if (inc[n]) begin
        cnt_d[n] = cnt_q[n] + COUNTER_WIDTH'(1);
        if (&cnt_q[n]) ovf_d[n] = 1'b1;
      end
      if (csr_we_i && csr_addr_i == ADDR_EV_BASE + 12'(n)) begin
        sel_d[n] = csr_wdata_i[7:0];
        wr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      if (csr_addr_i == ADDR_LO_BASE + 12'(n)) begin rd_hit = 1'b1; rd_val = cnt_q[n][31:0]; end
      if (csr_addr_i == ADDR_HI_BASE + 12'(n)) begin
        rd_hit = 1'b1;
        rd_val = 32'(cnt_q[n][COUNTER_WIDTH-1:32]);
      end
      if (csr_addr_i == ADDR_EV_BASE + 12'(n)) begin rd_hit = 1'b1; rd_val = {24'h0, sel_q[n]}; end
    end
    if (csr_addr_i == ADDR_INH)   begin rd_hit = 1'b1; rd_val = inh_vec;   end
    if (csr_addr_i == ADDR_OVF)   begin rd_hit = 1'b1; rd_val = ovf_vec;   end
    if (csr_addr_i == ADDR_OVFEN) begin rd_hit = 1'b1; rd_val = ovfen_vec; end

    rvalid_d = csr_re_i;
    rdata_d  = csr_re_i ? rd_val : rdata_q;
    err_d    = (csr_re_i && !rd_hit) || (csr_we_i && !wr_hit);
    irq_d    = |(ovf_q & ovfen_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        cnt_q[n] <= '0;
        sel_q[n] <= '0;
      end
      inh_q    <= '0;
      ovf_q    <= '0;
      ovfen_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      inh_q    <= inh_d;
      ovf_q    <= ovf_d;
      ovfen_q  <= ovfen_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign csr_rdata_o  = rdata_q;
  assign csr_rvalid_o = rvalid_q;
  assign csr_err_o    = err_q;
  assign irq_o        = irq_q;

endmodule

`default_nettype wire
